// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide UART transmitter between N_REQ
// requesters, locking it to one owner per packet with an optional tag byte.
module serial_tx_arbiter #(
    parameter int                   N_REQ        = 4,
    parameter int                   DATA_BITS    = 8,
    parameter int                   HEADER_EN    = 1,
    parameter logic [DATA_BITS-1:0] HDR_BASE     = 8'hA0,
    parameter int                   BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_BITS-1:0] req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           ack,
    output logic [DATA_BITS-1:0]       tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       locked,
    output logic                       err_timeout
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SEND    = 2'd1;
    localparam logic [1:0] S_WAIT_HI = 2'd2;
    localparam logic [1:0] S_WAIT_LO = 2'd3;

    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
    localparam logic [CW-1:0]    TO_LAST  = CW'(BUSY_TIMEOUT - 1);

    logic [1:0]           state;
    logic [IW-1:0]        rr_ptr;
    logic                 hdr_pend;
    logic                 last_r;
    logic [CW-1:0]        tcnt;

    logic                 arb_hit;
    logic [IW-1:0]        arb_idx;
    logic [DATA_BITS-1:0] hdr_byte;
    logic [DATA_BITS-1:0] own_data;
    logic                 own_req;
    logic                 own_last;

    // First set request bit searching upward from rr_ptr+1, wrapping around.
    always_comb begin
        int j;
        arb_hit = 1'b0;
        arb_idx = '0;
        j       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(rr_ptr) + k) % N_REQ;
            if (!arb_hit && req[j]) begin
                arb_hit = 1'b1;
                arb_idx = IW'(j);
            end
        end
    end

    always_comb begin
        hdr_byte         = HDR_BASE;
        hdr_byte[IW-1:0] = grant_id;
    end

    assign own_data = req_data[int'(grant_id)*DATA_BITS +: DATA_BITS];
    assign own_req  = req[grant_id];
    assign own_last = req_last[grant_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= IW'(N_REQ - 1);
            hdr_pend    <= 1'b0;
            last_r      <= 1'b0;
            tcnt        <= '0;
            ack         <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            grant_id    <= '0;
            locked      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            ack      <= '0;
            case (state)
                S_IDLE: begin
                    if (arb_hit) begin
                        grant_id <= arb_idx;
                        locked   <= 1'b1;
                        hdr_pend <= (HEADER_EN != 0);
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        if (hdr_pend) begin
                            tx_data  <= hdr_byte;
                            tx_start <= 1'b1;
                            hdr_pend <= 1'b0;
                            last_r   <= 1'b0;
                            tcnt     <= '0;
                            state    <= S_WAIT_HI;
                        end else if (own_req) begin
                            tx_data  <= own_data;
                            tx_start <= 1'b1;
                            ack      <= ONE_HOT0 << grant_id;
                            last_r   <= own_last;
                            tcnt     <= '0;
                            state    <= S_WAIT_HI;
                        end else begin
                            // Owner abandoned the packet: free the line without a strobe.
                            locked <= 1'b0;
                            rr_ptr <= grant_id;
                            state  <= S_IDLE;
                        end
                    end
                end
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        state <= S_WAIT_LO;
                    end else if (tcnt == TO_LAST) begin
                        // Busy never rose; treat the byte as consumed and move on.
                        err_timeout <= 1'b1;
                        state       <= S_WAIT_LO;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (last_r) begin
                            locked <= 1'b0;
                            rr_ptr <= grant_id;
                            state  <= S_IDLE;
                        end else begin
                            state <= S_SEND;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: requester queues and a transmitter model around the
// DUT, with a scoreboard of expected strobed bytes and owners.
module tb_serial_tx_arbiter;
    localparam int N      = 4;
    localparam int TX_LEN = 4;

    logic           clk, rst;
    logic [N-1:0]   req, req_last, ack;
    logic [N*8-1:0] req_data;
    logic [7:0]     tx_data;
    logic           tx_start, tx_busy;
    logic [1:0]     grant_id;
    logic           locked, err_timeout;

    serial_tx_arbiter #(
        .N_REQ(N), .DATA_BITS(8), .HEADER_EN(1), .HDR_BASE(8'hA0), .BUSY_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .ack(ack), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .locked(locked), .err_timeout(err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Transmitter model: busy rises the edge after a strobe and lasts TX_LEN cycles.
    logic stall;
    int   bcnt;
    always @(posedge clk) begin
        if (tx_start && !stall) begin
            tx_busy <= 1'b1;
            bcnt    <= TX_LEN;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) tx_busy <= 1'b0;
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       hdr;
        int         owner;
    } exp_t;

    typedef struct {
        logic [3:0]      mask;
        int              len;
        int              pk0;
        int              n;
        logic [3:0][1:0] ord;
        logic [2:0][7:0] d;
    } vec_t;

    exp_t       sb[$];
    logic [8:0] rq[N][$];
    int         strobes[$];
    int         nchk, nfail, cyc;
    logic       prev_start;
    vec_t       vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        nchk++;
        nfail++;
        $display("FAIL %s", nm);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() != 0) begin
                req[i]            = 1'b1;
                req_data[i*8 +: 8] = rq[i][0][7:0];
                req_last[i]       = rq[i][0][8];
            end else begin
                req[i]            = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    // One cycle: check what the DUT shows, consume acked bytes, present the next ones.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (tx_start === 1'b1) begin
            if (prev_start) fail("strobe_back_to_back");
            if (tx_busy) fail("strobe_while_busy");
            if (sb.size() == 0) begin
                fail("unexpected_strobe");
            end else begin
                e = sb.pop_front();
                chk("tx_data", 32'(tx_data), 32'(e.d));
                chk("ack", 32'(ack), e.hdr ? 32'd0 : (32'd1 << e.owner));
                chk("grant_id", 32'(grant_id), 32'(e.owner));
            end
            strobes.push_back(cyc);
        end else if (ack !== '0 && !rst) begin
            fail("ack_without_strobe");
        end
        prev_start = (tx_start === 1'b1);
        for (int i = 0; i < N; i++)
            if (ack[i] === 1'b1 && rq[i].size() != 0) void'(rq[i].pop_front());
        drive_reqs();
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_ack"}, 32'(ack), 32'd0);
        chk({nm, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({nm, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({nm, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({nm, "_locked"}, 32'(locked), 32'd0);
        chk({nm, "_err_timeout"}, 32'(err_timeout), 32'd0);
    endtask

    task automatic clear_all();
        sb.delete();
        for (int i = 0; i < N; i++) rq[i].delete();
        drive_reqs();
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        clear_all();
        step();
        check_reset(nm);
        rst = 1'b0;
    endtask

    task automatic exp_pkt(input int id, input int len, input logic [2:0][7:0] d);
        sb.push_back('{d: 8'hA0 | 8'(id), hdr: 1'b1, owner: id});
        for (int k = 0; k < len; k++) sb.push_back('{d: d[k], hdr: 1'b0, owner: id});
    endtask

    task automatic load_pkt(input int id, input int len, input logic [2:0][7:0] d, input logic last_en);
        for (int k = 0; k < len; k++) rq[id].push_back({last_en && (k == len - 1), d[k]});
    endtask

    function automatic bit busy_work();
        bit b = locked || (sb.size() != 0);
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        do begin
            step();
            n++;
        end while (busy_work() && n < budget);
        if (n >= budget) fail({nm, "_timeout"});
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [2:0][7:0] dd;
        int              n, pk;
        rst = 1'b1; stall = 1'b0; tx_busy = 1'b0; bcnt = 0;
        req = '0; req_last = '0; req_data = '0;
        nchk = 0; nfail = 0; cyc = 0; prev_start = 1'b0;

        vecs[0] = '{mask: 4'b0100, len: 2, pk0: 0, n: 1, ord: {2'd0, 2'd0, 2'd0, 2'd2}, d: {8'h33, 8'h22, 8'h11}};
        vecs[1] = '{mask: 4'b1011, len: 1, pk0: 2, n: 4, ord: {2'd0, 2'd3, 2'd1, 2'd0}, d: {8'h00, 8'h00, 8'h5A}};
        vecs[2] = '{mask: 4'b0011, len: 3, pk0: 1, n: 2, ord: {2'd0, 2'd0, 2'd1, 2'd0}, d: {8'hC3, 8'hB2, 8'hA1}};
        vecs[3] = '{mask: 4'b1111, len: 1, pk0: 1, n: 4, ord: {2'd3, 2'd2, 2'd1, 2'd0}, d: {8'h00, 8'h00, 8'hFF}};
        vecs[4] = '{mask: 4'b1100, len: 2, pk0: 1, n: 2, ord: {2'd0, 2'd0, 2'd3, 2'd2}, d: {8'h00, 8'h01, 8'h80}};

        idle_steps(2);
        for (int v = 0; v < 5; v++) begin
            do_reset("rst_vec");
            for (int k = 0; k < vecs[v].n; k++) exp_pkt(int'(vecs[v].ord[k]), vecs[v].len, vecs[v].d);
            for (int i = 0; i < N; i++) begin
                if (vecs[v].mask[i]) begin
                    pk = (i == 0 && vecs[v].pk0 > 0) ? vecs[v].pk0 : 1;
                    for (int p = 0; p < pk; p++) load_pkt(i, vecs[v].len, vecs[v].d, 1'b1);
                end
            end
            drive_reqs();
            wait_done(400, "vec");
            chk("vec_locked_end", 32'(locked), 32'd0);
            chk("vec_last_grant", 32'(grant_id), 32'(vecs[v].ord[vecs[v].n - 1]));
        end

        // Lock: requester 1 arrives after requester 0's first data byte is taken.
        do_reset("rst_lock");
        dd = {8'h03, 8'h02, 8'h01};
        exp_pkt(0, 3, dd);
        exp_pkt(1, 1, {8'h00, 8'h00, 8'h77});
        load_pkt(0, 3, dd, 1'b1);
        drive_reqs();
        n = 0;
        while (rq[0].size() == 3 && n < 50) begin step(); n++; end
        if (n >= 50) fail("lock_first_ack_timeout");
        load_pkt(1, 1, {8'h00, 8'h00, 8'h77}, 1'b1);
        drive_reqs();
        wait_done(200, "lock");

        // Owner drops req after one byte: no more strobes, then rr_ptr = 0 so 1 wins.
        do_reset("rst_drop");
        exp_pkt(0, 1, {8'h00, 8'h00, 8'h44});
        load_pkt(0, 1, {8'h00, 8'h00, 8'h44}, 1'b0);
        drive_reqs();
        wait_done(100, "drop");
        idle_steps(6);
        chk("drop_locked", 32'(locked), 32'd0);
        exp_pkt(1, 1, {8'h00, 8'h00, 8'h61});
        exp_pkt(0, 1, {8'h00, 8'h00, 8'h60});
        load_pkt(0, 1, {8'h00, 8'h00, 8'h60}, 1'b1);
        load_pkt(1, 1, {8'h00, 8'h00, 8'h61}, 1'b1);
        drive_reqs();
        wait_done(200, "drop_rr");
        chk("drop_rr_last_grant", 32'(grant_id), 32'd0);

        // Timeout: transmitter never raises busy.
        do_reset("rst_to");
        stall = 1'b1;
        strobes.delete();
        exp_pkt(0, 2, {8'h00, 8'h9B, 8'h9A});
        load_pkt(0, 2, {8'h00, 8'h9B, 8'h9A}, 1'b1);
        drive_reqs();
        step();
        chk("to_err_before", 32'(err_timeout), 32'd0);
        wait_done(300, "to");
        chk("to_err_set", 32'(err_timeout), 32'd1);
        if (strobes.size() >= 2) chk("to_strobe_gap", 32'(strobes[1] - strobes[0]), 32'd18);
        else fail("to_strobe_count");
        stall = 1'b0;
        idle_steps(5);
        chk("to_err_sticky", 32'(err_timeout), 32'd1);
        do_reset("rst_to_clear");

        // Reset while in WAIT_LO, then requester 0 beats requester 3.
        dd = {8'h00, 8'h22, 8'h21};
        exp_pkt(2, 2, dd);
        load_pkt(2, 2, dd, 1'b1);
        drive_reqs();
        n = 0;
        while (tx_busy !== 1'b1 && n < 50) begin step(); n++; end
        if (n >= 50) fail("wlo_busy_timeout");
        step();
        do_reset("rst_wait_lo");
        exp_pkt(0, 1, {8'h00, 8'h00, 8'hD0});
        exp_pkt(3, 1, {8'h00, 8'h00, 8'hD3});
        load_pkt(3, 1, {8'h00, 8'h00, 8'hD3}, 1'b1);
        load_pkt(0, 1, {8'h00, 8'h00, 8'hD0}, 1'b1);
        drive_reqs();
        wait_done(200, "wlo");
        chk("wlo_last_grant", 32'(grant_id), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
